// File: rtl/ifetch_if.sv
// ifetch_if: PC-stage, instruction-memory and decode-side signals of the fetch stage
interface ifetch_if #(parameter int AW = 32, parameter int DW = 32);
  logic [AW-1:0] pc;
  logic          redirect;
  logic          pc_hold;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [DW-1:0] imem_rdata;
  logic          inst_valid;
  logic [DW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          inst_ready;
  modport master (
    input  pc, redirect, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output pc_hold, imem_req, imem_addr, inst_valid, inst, inst_pc
  );
  modport slave (
    output pc, redirect, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  pc_hold, imem_req, imem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/ifetch.sv
// ifetch: single-outstanding instruction fetch into a 2-entry FIFO with redirect flush
module ifetch #(parameter int AW = 32, parameter int DW = 32) (
  input logic   clk,
  input logic   rst,
  ifetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t        state, state_nx;
  logic          kill, kill_nx;
  logic [AW-1:0] tag;
  logic [AW-1:0] pc_q [2];
  logic [DW-1:0] data_q [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    count, count_nx;
  logic          fire, push, pop;
  always_comb begin
    bus.imem_req   = state == REQ && !bus.redirect;
    bus.imem_addr  = state == REQ ? {bus.pc[AW-1:2], 2'b00} : '0;
    fire           = bus.imem_req && bus.imem_gnt;
    bus.pc_hold    = !bus.redirect && !fire;
    push           = state == WAIT && bus.imem_rvalid && !kill && !bus.redirect;
    bus.inst_valid = count != 2'd0;
    pop            = bus.inst_valid && bus.inst_ready && !bus.redirect;
    count_nx       = bus.redirect ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
    bus.inst       = bus.inst_valid ? data_q[rd_ptr] : DW'(32'h0000_0013);
    bus.inst_pc    = bus.inst_valid ? pc_q[rd_ptr] : '0;
    state_nx       = state;
    kill_nx        = kill;
    case (state)
      IDLE: state_nx = count_nx < 2'd2 ? REQ : IDLE;
      REQ:  state_nx = fire ? WAIT : REQ;
      WAIT: begin
        // a response arriving with a redirect is stale too, so it is simply not pushed
        if (bus.imem_rvalid) begin
          state_nx = count_nx < 2'd2 ? REQ : IDLE;
          kill_nx  = 1'b0;
        end else if (bus.redirect) kill_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      kill   <= 1'b0;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      tag    <= '0;
    end else begin
      state <= state_nx;
      kill  <= kill_nx;
      count <= count_nx;
      if (fire) tag <= bus.pc;
      if (bus.redirect) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop) rd_ptr <= ~rd_ptr;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= bus.imem_rdata;
      pc_q[wr_ptr]   <= tag;
    end
  end
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed cycle-by-cycle vectors with hand-computed expectations for ifetch
module tb_ifetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  ifetch_if #(.AW(32), .DW(32)) bus();
  ifetch #(.AW(32), .DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic [31:0] p, input logic rd, input logic g,
                     input logic v, input logic [31:0] d, input logic rdy);
    @(posedge clk);
    #1;
    rst = r;
    bus.pc = p;
    bus.redirect = rd;
    bus.imem_gnt = g;
    bus.imem_rvalid = v;
    bus.imem_rdata = d;
    bus.inst_ready = rdy;
    #1;
  endtask
  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, {31'b0, bus.inst_valid}, 32'd0);
    chk({tag, "_inst"}, bus.inst, NOP);
    chk({tag, "_ipc"}, bus.inst_pc, 32'h0);
  endtask
  initial begin
    bus.pc = '0;
    bus.redirect = 1'b0;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    bus.inst_ready = 1'b1;
    // cycle 0: in reset
    cyc(0, 32'h0, 0, 1, 0, 32'h0, 1);
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_hold", {31'b0, bus.pc_hold}, 32'd1);
    chk_empty("rst");
    // cycle 1: released, still idle
    cyc(1, 32'h0, 0, 1, 0, 32'h0, 1);
    chk("c1_req", {31'b0, bus.imem_req}, 32'd0);
    chk("c1_hold", {31'b0, bus.pc_hold}, 32'd1);
    // cycle 2: request and grant
    cyc(1, 32'h0, 0, 1, 0, 32'h0, 1);
    chk("c2_req", {31'b0, bus.imem_req}, 32'd1);
    chk("c2_addr", bus.imem_addr, 32'h0);
    chk("c2_hold", {31'b0, bus.pc_hold}, 32'd0);
    // cycle 3: response
    cyc(1, 32'h4, 0, 1, 1, 32'h0050_0093, 1);
    chk("c3_req", {31'b0, bus.imem_req}, 32'd0);
    chk("c3_valid", {31'b0, bus.inst_valid}, 32'd0);
    // cycle 4: instruction visible, popped
    cyc(1, 32'h4, 0, 0, 0, 32'h0, 1);
    chk("c4_valid", {31'b0, bus.inst_valid}, 32'd1);
    chk("c4_inst", bus.inst, 32'h0050_0093);
    chk("c4_ipc", bus.inst_pc, 32'h0);
    chk("c4_addr", bus.imem_addr, 32'h4);
    // redirect while requesting 0x4, target 0x10
    cyc(1, 32'h10, 1, 1, 0, 32'h0, 1);
    chk_empty("redir_req");
    chk("redir_req_req", {31'b0, bus.imem_req}, 32'd0);
    chk("redir_req_hold", {31'b0, bus.pc_hold}, 32'd0);
    // grant stall
    for (int i = 0; i < 3; i++) begin
      cyc(1, 32'h10, 0, 0, 0, 32'h0, 1);
      chk("stall_req", {31'b0, bus.imem_req}, 32'd1);
      chk("stall_addr", bus.imem_addr, 32'h10);
      chk("stall_hold", {31'b0, bus.pc_hold}, 32'd1);
    end
    cyc(1, 32'h10, 0, 1, 0, 32'h0, 0);
    chk("stall_gnt_hold", {31'b0, bus.pc_hold}, 32'd0);
    // backpressure: fill FIFO with 0x10, 0x14
    cyc(1, 32'h14, 0, 0, 1, 32'h0000_00a0, 0);
    cyc(1, 32'h14, 0, 1, 0, 32'h0, 0);
    chk("bp1_inst", bus.inst, 32'h0000_00a0);
    chk("bp1_ipc", bus.inst_pc, 32'h10);
    chk("bp1_addr", bus.imem_addr, 32'h14);
    cyc(1, 32'h18, 0, 1, 1, 32'h0000_00a4, 0);
    chk("bp2_inst", bus.inst, 32'h0000_00a0);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 32'h18, 0, 1, 0, 32'h0, 0);
      chk("full_req", {31'b0, bus.imem_req}, 32'd0);
      chk("full_hold", {31'b0, bus.pc_hold}, 32'd1);
      chk("full_inst", bus.inst, 32'h0000_00a0);
    end
    cyc(1, 32'h18, 0, 0, 0, 32'h0, 1);
    chk("pop1_inst", bus.inst, 32'h0000_00a0);
    chk("pop1_ipc", bus.inst_pc, 32'h10);
    cyc(1, 32'h18, 0, 0, 0, 32'h0, 1);
    chk("pop2_inst", bus.inst, 32'h0000_00a4);
    chk("pop2_ipc", bus.inst_pc, 32'h14);
    chk("resume_req", {31'b0, bus.imem_req}, 32'd1);
    chk("resume_addr", bus.imem_addr, 32'h18);
    // misaligned pc
    cyc(1, 32'h22, 0, 1, 0, 32'h0, 1);
    chk_empty("mis");
    chk("mis_addr", bus.imem_addr, 32'h20);
    cyc(1, 32'h26, 0, 0, 1, 32'h0000_00b0, 0);
    cyc(1, 32'h20, 0, 1, 0, 32'h0, 0);
    chk("mis_inst", bus.inst, 32'h0000_00b0);
    chk("mis_ipc", bus.inst_pc, 32'h22);
    chk("mis_hold", {31'b0, bus.pc_hold}, 32'd0);
    // redirect while waiting for 0x20, target 0x100
    cyc(1, 32'h100, 1, 0, 0, 32'h0, 0);
    chk("rw_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rw_hold", {31'b0, bus.pc_hold}, 32'd0);
    cyc(1, 32'h100, 0, 1, 1, 32'h0000_dead, 1);
    chk_empty("rw_flush");
    chk("rw_kill_req", {31'b0, bus.imem_req}, 32'd0);
    cyc(1, 32'h100, 0, 1, 0, 32'h0, 0);
    chk_empty("rw_drop");
    chk("rw_new_addr", bus.imem_addr, 32'h100);
    cyc(1, 32'h104, 0, 0, 1, 32'h0000_00c0, 0);
    cyc(1, 32'h104, 0, 1, 0, 32'h0, 0);
    chk("rw_inst", bus.inst, 32'h0000_00c0);
    chk("rw_ipc", bus.inst_pc, 32'h100);
    // reset while waiting with one entry
    cyc(0, 32'h104, 0, 0, 0, 32'h0, 0);
    cyc(1, 32'h104, 0, 0, 1, 32'h0000_00ee, 0);
    chk_empty("mrst");
    chk("mrst_req", {31'b0, bus.imem_req}, 32'd0);
    // redirect with grant in REQ: grant ignored
    cyc(1, 32'h200, 1, 1, 0, 32'h0, 0);
    chk_empty("stray");
    chk("rg_req", {31'b0, bus.imem_req}, 32'd0);
    cyc(1, 32'h200, 0, 0, 0, 32'h0, 0);
    chk("rg_req2", {31'b0, bus.imem_req}, 32'd1);
    chk("rg_addr", bus.imem_addr, 32'h200);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter AW, default 32: address width.
REQ-002 Parameter DW, default 32: instruction/data width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low (rst==0 at a rising edge resets).
REQ-005 pc  input  AW  current fetch address from the PC stage.
REQ-006 redirect  input  1  same signal as PC-stage pc_sel; 1 = control-flow change, flush fetch.
REQ-007 pc_hold  output  1  1 = PC stage must not advance this cycle.
REQ-008 imem_req  output  1  instruction-memory request valid.
REQ-009 imem_addr  output  AW  word-aligned request address.
REQ-010 imem_gnt  input  1  memory accepts request this cycle.
REQ-011 imem_rvalid  input  1  response data valid.
REQ-012 imem_rdata  input  DW  response instruction word.
REQ-013 inst_valid  output  1  instruction available to decode.
REQ-014 inst  output  DW  instruction word (FIFO head).
REQ-015 inst_pc  output  AW  address of inst.
REQ-016 inst_ready  input  1  decode consumes head when inst_valid & inst_ready.

Function
REQ-017 FSM states: IDLE, REQ, WAIT; at most one outstanding memory request.
REQ-018 IDLE: imem_req=0; go to REQ next cycle if credit available.
REQ-019 Credit: request issued only when fifo_count + outstanding < 2.
REQ-020 REQ: imem_req=1, imem_addr={pc[AW-1:2],2'b00}; hold request and address stable until imem_gnt; on gnt latch pc into tag register, go to WAIT.
REQ-021 pc_hold = ~(imem_req & imem_gnt), except pc_hold=0 when redirect=1 so PC stage loads target.
REQ-022 WAIT: on imem_rvalid push {tag, imem_rdata} into 2-entry FIFO; next state REQ if credit after push, else IDLE.
REQ-023 imem_rvalid outside WAIT shall be ignored.
REQ-024 Output registered: earliest inst_valid is cycle after imem_rvalid; gnt in cycle N, rvalid N+1 -> inst_valid N+2.
REQ-025 FIFO: push and pop in same cycle allowed at any count; count unchanged, order preserved; pointers wrap modulo 2.
REQ-026 inst_valid = (fifo_count != 0); when empty inst=32'h0000_0013 (NOP), inst_pc=0.
REQ-027 inst/inst_pc shall hold stable while inst_valid & ~inst_ready.
REQ-028 redirect: FIFO cleared same edge (count=0); imem_req forced 0 that cycle; next state REQ with new pc.
REQ-029 redirect in WAIT: set kill flag; next imem_rvalid is dropped (no push), kill cleared, then continue REQ; new request not issued until kill cleared.
REQ-030 redirect in REQ before gnt: request withdrawn, no tag latched; gnt in the redirect cycle is ignored.
REQ-031 redirect and inst_ready same cycle: flush wins, no pop counted.

Reset
REQ-032 rst==0 at edge: state=IDLE, fifo_count=0, pointers=0, kill=0, outstanding=0.
REQ-033 During and after reset until first REQ: imem_req=0, imem_addr=0, inst_valid=0, inst=NOP, inst_pc=0, pc_hold=1.
REQ-034 Reset mid-WAIT: pending response abandoned; a later imem_rvalid shall be ignored (state not WAIT).

Verification
REQ-035 Reset release, pc=0x0, gnt=1 always, rvalid one cycle after gnt, rdata=0x00500093, inst_ready=1 -> imem_req cycle 2, inst_valid cycle 4 with inst=0x00500093, inst_pc=0x0; pc_hold low in grant cycle.
REQ-036 Backpressure: inst_ready=0, pcs 0x0,0x4,0x8 -> FIFO fills with 0x0,0x4; no third request, pc_hold=1 stays; inst_ready=1 -> pops in order, request for 0x8 resumes.
REQ-037 Grant stall: gnt=0 for 3 cycles at pc=0x10 -> imem_req=1, imem_addr=0x10 stable, pc_hold=1 all 3 cycles.
REQ-038 Redirect in WAIT (outstanding 0x20, target 0x100) -> FIFO emptied, response for 0x20 dropped, next inst_pc=0x100.
REQ-039 Misaligned pc=0x22 -> imem_addr=0x20, inst_pc=0x22.
REQ-040 rst=0 while WAIT with 1 FIFO entry -> next cycle inst_valid=0, imem_req=0; stray rvalid produces no entry.
